// File: rtl/udp_to_sample_stream.sv
// Receive-side depacketizer: validates the 8-byte sample-link header, strips it and
// forwards the payload beats through a single output register, tracking drops and gaps.
module udp_to_sample_stream #(
  parameter int          C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int          C_S00_AXIS_TKEEP_WIDTH = 8,
  parameter int          C_M00_AXIS_TDATA_WIDTH = 64,
  parameter logic [15:0] MAGIC                  = 16'hA55A,
  parameter int          MAX_BEATS              = 2048
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [C_S00_AXIS_TKEEP_WIDTH-1:0] s00_axis_tkeep,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  input  logic                              s00_axis_tuser,
  output logic                              s00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  output logic                              m00_axis_tuser,
  input  logic                              m00_axis_tready,
  output logic [31:0]                       seq_expected,
  output logic [31:0]                       frame_count,
  output logic [15:0]                       drop_count,
  output logic [15:0]                       gap_count,
  output logic                              locked
);

  localparam int          IDX_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] beat_idx;
  logic [IDX_W-1:0] beat_end;     // N-1, index of the final payload beat
  logic             sticky_err;

  logic [15:0] hdr_magic;
  logic [15:0] hdr_len;
  logic [31:0] hdr_seq;
  logic        hdr_ok;
  logic        beat_err;
  logic        in_fire;

  logic ready_int;
  logic hdr_accept;
  logic hdr_drop;
  logic load_out;
  logic load_last;
  logic load_user;

  assign hdr_magic = s00_axis_tdata[63:48];
  assign hdr_len   = s00_axis_tdata[47:32];
  assign hdr_seq   = s00_axis_tdata[31:0];
  assign hdr_ok    = (hdr_magic == MAGIC) && (hdr_len != 16'd0) &&
                     (hdr_len <= MAX_LEN) && !s00_axis_tlast;
  assign beat_err  = s00_axis_tuser || (s00_axis_tkeep != '1);

  // Ready is forced low while reset is held so no beat is taken during reset.
  assign s00_axis_tready = ready_int && s00_axis_aresetn;
  assign in_fire         = s00_axis_tvalid && s00_axis_tready;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state <= IDLE;
    else                   state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, otherwise a branch that
  // skips an assignment would infer a latch.
  always_comb begin
    state_nxt  = state;
    ready_int  = 1'b1;
    hdr_accept = 1'b0;
    hdr_drop   = 1'b0;
    load_out   = 1'b0;
    load_last  = 1'b0;
    load_user  = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_fire) begin
          if (hdr_ok) begin
            hdr_accept = 1'b1;
            state_nxt  = PAYLOAD;
          end else begin
            hdr_drop  = 1'b1;
            state_nxt = s00_axis_tlast ? IDLE : DISCARD;
          end
        end
      end

      PAYLOAD: begin
        ready_int = !m00_axis_tvalid || m00_axis_tready;
        if (in_fire) begin
          load_out = 1'b1;
          if (beat_idx == beat_end) begin
            load_last = 1'b1;
            if (s00_axis_tlast) begin
              load_user = sticky_err || beat_err;
              state_nxt = IDLE;
            end else begin
              // Frame runs past its declared length: close it as bad, drop the rest.
              load_user = 1'b1;
              state_nxt = DISCARD;
            end
          end else if (s00_axis_tlast) begin
            load_last = 1'b1;
            load_user = 1'b1;
            state_nxt = IDLE;
          end
        end
      end

      DISCARD: begin
        if (in_fire && s00_axis_tlast) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      beat_idx     <= '0;
      beat_end     <= '0;
      sticky_err   <= 1'b0;
      seq_expected <= '0;
      frame_count  <= '0;
      drop_count   <= '0;
      gap_count    <= '0;
      locked       <= 1'b0;
    end else begin
      if (hdr_accept) begin
        beat_idx     <= '0;
        beat_end     <= IDX_W'(hdr_len - 16'd1);
        sticky_err   <= 1'b0;
        locked       <= 1'b1;
        seq_expected <= hdr_seq + 32'd1;
        if (locked && (hdr_seq != seq_expected) && (gap_count != 16'hFFFF))
          gap_count <= gap_count + 16'd1;
      end

      if (hdr_drop && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;

      if (load_out && !load_last) begin
        beat_idx   <= beat_idx + 1'b1;
        sticky_err <= sticky_err || beat_err;
      end

      if (load_out && load_last)
        frame_count <= frame_count + 32'd1;
    end
  end

  // Single output register; stalls hold data/last/user until the sink takes them.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tuser  <= 1'b0;
    end else if (load_out) begin
      m00_axis_tdata  <= s00_axis_tdata;
      m00_axis_tvalid <= 1'b1;
      m00_axis_tlast  <= load_last;
      m00_axis_tuser  <= load_user;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_to_sample_stream.sv
// Directed bench for udp_to_sample_stream: hand-built frames, expected output beats
// kept in a queue and matched in order, counters compared after each scenario.
module tb_udp_to_sample_stream;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic [31:0] seq_expected;
  logic [31:0] frame_count;
  logic [15:0] drop_count;
  logic [15:0] gap_count;
  logic        locked;

  udp_to_sample_stream dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tkeep   (s_tkeep),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tuser   (s_tuser),
    .s00_axis_tready  (s_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tuser   (m_tuser),
    .m00_axis_tready  (m_tready),
    .seq_expected     (seq_expected),
    .frame_count      (frame_count),
    .drop_count       (drop_count),
    .gap_count        (gap_count),
    .locked           (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] pay_word = 64'h007CB66BA55A0000;
  logic [63:0] base;
  logic [63:0] held;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs and ready are stable at the falling edge; a beat seen here is taken next edge.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("out_extra_beat", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", m_tdata, mon_e.d);
        check("out_last", {63'd0, m_tlast}, {63'd0, mon_e.l});
        check("out_user", {63'd0, m_tuser}, {63'd0, mon_e.u});
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic u);
    int n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n >= 200) begin
        check("handshake_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] magic, input logic [15:0] len,
                          input logic [31:0] seq, input logic l);
    send_beat({magic, len, seq}, 8'hFF, l, 1'b0);
  endtask

  // cnt payload beats from the running counter; err_at/keep_at mark a bad beat (-1 = none).
  task automatic send_payload(input int cnt, input logic last_on_end,
                              input int err_at, input int keep_at);
    for (int i = 0; i < cnt; i++) begin
      send_beat(pay_word, (i == keep_at) ? 8'h0F : 8'hFF,
                last_on_end && (i == cnt - 1), i == err_at);
      pay_word = pay_word + 64'd1;
    end
  endtask

  task automatic exp_push(input logic [63:0] d, input logic l, input logic u);
    exp_q.push_back('{d: d, l: l, u: u});
  endtask

  task automatic good_frame(input int n, input logic [31:0] seq);
    for (int i = 0; i < n; i++) exp_push(pay_word + 64'(i), i == n - 1, 1'b0);
    send_hdr(16'hA55A, 16'(n), seq, 1'b0);
    send_payload(n, 1'b1, -1, -1);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tready", {63'd0, s_tready}, 64'd0);
    check("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_seq", 64'(seq_expected), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("tready_after_rst", {63'd0, s_tready}, 64'd1);

    // Two good frames back to back
    good_frame(4, 32'd0);
    good_frame(4, 32'd1);
    drain("good_drain");
    check("good_frames", 64'(frame_count), 64'd2);
    check("good_gap", 64'(gap_count), 64'd0);
    check("good_seq", 64'(seq_expected), 64'd2);
    check("good_locked", {63'd0, locked}, 64'd1);

    // Sequence gap, then rejected headers of every kind
    do_reset();
    good_frame(2, 32'd5);
    check("gap_first_lock", 64'(gap_count), 64'd0);
    good_frame(2, 32'd9);
    drain("gap_drain");
    check("gap_count", 64'(gap_count), 64'd1);
    check("gap_seq", 64'(seq_expected), 64'd10);
    send_hdr(16'h1234, 16'd2, 32'd10, 1'b0);
    send_payload(3, 1'b1, -1, -1);
    drain("badmagic_no_out");
    check("drop_magic", 64'(drop_count), 64'd1);
    send_hdr(16'hA55A, 16'd0, 32'd10, 1'b0);
    send_payload(1, 1'b1, -1, -1);
    send_hdr(16'hA55A, 16'd2, 32'd10, 1'b1);
    send_hdr(16'hA55A, 16'd2049, 32'd10, 1'b0);
    send_payload(1, 1'b1, -1, -1);
    good_frame(2, 32'd10);
    drain("after_drop_drain");
    check("drop_all", 64'(drop_count), 64'd4);
    check("drop_gap_same", 64'(gap_count), 64'd1);
    check("drop_seq", 64'(seq_expected), 64'd11);
    check("drop_frames", 64'(frame_count), 64'd3);

    // Early tlast, then a long frame
    base = pay_word;
    exp_push(base, 1'b0, 1'b0);
    exp_push(base + 64'd1, 1'b1, 1'b1);
    send_hdr(16'hA55A, 16'd4, 32'd11, 1'b0);
    send_payload(2, 1'b1, -1, -1);
    base = pay_word;
    exp_push(base, 1'b0, 1'b0);
    exp_push(base + 64'd1, 1'b1, 1'b1);
    send_hdr(16'hA55A, 16'd2, 32'd12, 1'b0);
    send_payload(4, 1'b1, -1, -1);
    drain("len_drain");
    check("len_frames", 64'(frame_count), 64'd5);
    check("len_drop_same", 64'(drop_count), 64'd4);

    // Backpressure for 10 cycles mid-frame
    fork
      good_frame(16, 32'd13);
      begin
        repeat (6) @(posedge clk);
        #1;
        m_tready = 1'b0;
        held = m_tdata;
        repeat (10) begin
          @(negedge clk);
          check("stall_tready", {63'd0, s_tready}, 64'd0);
          check("stall_hold", m_tdata, held);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_frames", 64'(frame_count), 64'd6);

    // MAC error on the first payload beat, then a partial tkeep on a last beat
    base = pay_word;
    exp_push(base, 1'b0, 1'b0);
    exp_push(base + 64'd1, 1'b0, 1'b0);
    exp_push(base + 64'd2, 1'b1, 1'b1);
    send_hdr(16'hA55A, 16'd3, 32'd14, 1'b0);
    send_payload(3, 1'b1, 0, -1);
    base = pay_word;
    exp_push(base, 1'b0, 1'b0);
    exp_push(base + 64'd1, 1'b1, 1'b1);
    send_hdr(16'hA55A, 16'd2, 32'd15, 1'b0);
    send_payload(2, 1'b1, -1, 1);
    drain("err_drain");
    check("err_frames", 64'(frame_count), 64'd8);
    check("err_seq", 64'(seq_expected), 64'd16);
    check("err_gap", 64'(gap_count), 64'd1);

    // Reset in the middle of a frame
    base = pay_word;
    exp_push(base, 1'b0, 1'b0);
    send_hdr(16'hA55A, 16'd4, 32'd16, 1'b0);
    send_payload(2, 1'b0, -1, -1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_lost_beat", 64'(exp_q.size()), 64'd0);
    check("mid_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("mid_rst_tdata", m_tdata, 64'd0);
    check("mid_rst_tlast", {62'd0, m_tlast, m_tuser}, 64'd0);
    check("mid_rst_tready", {63'd0, s_tready}, 64'd0);
    check("mid_rst_counts", {frame_count, drop_count, gap_count}, 64'd0);
    check("mid_rst_seq", {31'd0, locked, seq_expected}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_payload(2, 1'b1, -1, -1);
    drain("mid_rst_discard");
    check("mid_rst_drop", 64'(drop_count), 64'd1);
    good_frame(2, 32'd40);
    drain("post_rst_drain");
    check("post_rst_frames", 64'(frame_count), 64'd1);
    check("post_rst_gap", 64'(gap_count), 64'd0);
    check("post_rst_seq", 64'(seq_expected), 64'd41);
    check("post_rst_locked", {63'd0, locked}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
